// File: rtl/ysyx_24110006_axi_arbiter.sv
// Two-master AXI4 arbiter: IFU (M0, read-only) and LSU (M1, read/write) share one memory slave.
// One whole transaction is granted at a time, round-robin; responses return only to the owner.
module ysyx_24110006_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                i_clock,
  input  logic                i_reset,
  // M0 (IFU) read
  input  logic                i_m0_arvalid,
  input  logic [ADDR_W-1:0]   i_m0_araddr,
  input  logic [3:0]          i_m0_arid,
  input  logic [7:0]          i_m0_arlen,
  input  logic [2:0]          i_m0_arsize,
  input  logic [1:0]          i_m0_arburst,
  output logic                o_m0_arready,
  output logic                o_m0_rvalid,
  output logic [DATA_W-1:0]   o_m0_rdata,
  output logic [1:0]          o_m0_rresp,
  output logic                o_m0_rlast,
  output logic [3:0]          o_m0_rid,
  input  logic                i_m0_rready,
  // M1 (LSU) read
  input  logic                i_m1_arvalid,
  input  logic [ADDR_W-1:0]   i_m1_araddr,
  input  logic [3:0]          i_m1_arid,
  input  logic [7:0]          i_m1_arlen,
  input  logic [2:0]          i_m1_arsize,
  input  logic [1:0]          i_m1_arburst,
  output logic                o_m1_arready,
  output logic                o_m1_rvalid,
  output logic [DATA_W-1:0]   o_m1_rdata,
  output logic [1:0]          o_m1_rresp,
  output logic                o_m1_rlast,
  output logic [3:0]          o_m1_rid,
  input  logic                i_m1_rready,
  // M1 (LSU) write
  input  logic                i_m1_awvalid,
  input  logic [ADDR_W-1:0]   i_m1_awaddr,
  input  logic [3:0]          i_m1_awid,
  input  logic [7:0]          i_m1_awlen,
  input  logic [2:0]          i_m1_awsize,
  input  logic [1:0]          i_m1_awburst,
  output logic                o_m1_awready,
  input  logic                i_m1_wvalid,
  input  logic [DATA_W-1:0]   i_m1_wdata,
  input  logic [DATA_W/8-1:0] i_m1_wstrb,
  input  logic                i_m1_wlast,
  output logic                o_m1_wready,
  output logic                o_m1_bvalid,
  output logic [1:0]          o_m1_bresp,
  output logic [3:0]          o_m1_bid,
  input  logic                i_m1_bready,
  // Slave side
  output logic                o_s_awvalid,
  output logic [ADDR_W-1:0]   o_s_awaddr,
  output logic [3:0]          o_s_awid,
  output logic [7:0]          o_s_awlen,
  output logic [2:0]          o_s_awsize,
  output logic [1:0]          o_s_awburst,
  input  logic                i_s_awready,
  output logic                o_s_wvalid,
  output logic [DATA_W-1:0]   o_s_wdata,
  output logic [DATA_W/8-1:0] o_s_wstrb,
  output logic                o_s_wlast,
  input  logic                i_s_wready,
  input  logic                i_s_bvalid,
  input  logic [1:0]          i_s_bresp,
  input  logic [3:0]          i_s_bid,
  output logic                o_s_bready,
  output logic                o_s_arvalid,
  output logic [ADDR_W-1:0]   o_s_araddr,
  output logic [3:0]          o_s_arid,
  output logic [7:0]          o_s_arlen,
  output logic [2:0]          o_s_arsize,
  output logic [1:0]          o_s_arburst,
  input  logic                i_s_arready,
  input  logic                i_s_rvalid,
  input  logic [DATA_W-1:0]   i_s_rdata,
  input  logic [1:0]          i_s_rresp,
  input  logic                i_s_rlast,
  input  logic [3:0]          i_s_rid,
  output logic                o_s_rready,
  // Debug
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_M0_RD = 2'd1,
    S_M1_RD = 2'd2,
    S_M1_WR = 2'd3
  } state_t;

  state_t state_q;
  logic   last_grant_q;
  logic   ar_done_q;
  logic   aw_done_q;
  logic   w_done_q;

  logic req0;
  logic req1;
  logic ar_hs;
  logic aw_hs;
  logic w_hs;
  logic r_end;
  logic b_end;

  assign req0  = i_m0_arvalid;
  assign req1  = i_m1_arvalid | i_m1_awvalid;
  assign ar_hs = o_s_arvalid & i_s_arready;
  assign aw_hs = o_s_awvalid & i_s_awready;
  assign w_hs  = o_s_wvalid & i_s_wready;
  assign r_end = i_s_rvalid & o_s_rready & i_s_rlast;
  assign b_end = i_s_bvalid & o_s_bready;

  assign o_dbg_state = state_q;

  // Done flags stop an already-accepted address/data beat from being reissued
  // while the master keeps its valid high.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      ar_done_q    <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ar_done_q <= 1'b0;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          if (req0 && (!req1 || last_grant_q)) begin
            state_q      <= S_M0_RD;
            last_grant_q <= 1'b0;
          end else if (req1) begin
            state_q      <= i_m1_awvalid ? S_M1_WR : S_M1_RD;
            last_grant_q <= 1'b1;
          end
        end
        S_M0_RD, S_M1_RD: begin
          if (ar_hs) ar_done_q <= 1'b1;
          if (r_end) begin
            state_q   <= S_IDLE;
            ar_done_q <= 1'b0;
          end
        end
        S_M1_WR: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
          if (b_end) begin
            state_q   <= S_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Pure combinational routing: everything defaults to zero, the owner's paths are opened.
  always_comb begin
    o_m0_arready = 1'b0;
    o_m0_rvalid  = 1'b0;
    o_m0_rdata   = '0;
    o_m0_rresp   = '0;
    o_m0_rlast   = 1'b0;
    o_m0_rid     = '0;
    o_m1_arready = 1'b0;
    o_m1_rvalid  = 1'b0;
    o_m1_rdata   = '0;
    o_m1_rresp   = '0;
    o_m1_rlast   = 1'b0;
    o_m1_rid     = '0;
    o_m1_awready = 1'b0;
    o_m1_wready  = 1'b0;
    o_m1_bvalid  = 1'b0;
    o_m1_bresp   = '0;
    o_m1_bid     = '0;
    o_s_awvalid  = 1'b0;
    o_s_awaddr   = '0;
    o_s_awid     = '0;
    o_s_awlen    = '0;
    o_s_awsize   = '0;
    o_s_awburst  = '0;
    o_s_wvalid   = 1'b0;
    o_s_wdata    = '0;
    o_s_wstrb    = '0;
    o_s_wlast    = 1'b0;
    o_s_bready   = 1'b0;
    o_s_arvalid  = 1'b0;
    o_s_araddr   = '0;
    o_s_arid     = '0;
    o_s_arlen    = '0;
    o_s_arsize   = '0;
    o_s_arburst  = '0;
    o_s_rready   = 1'b0;
    case (state_q)
      S_M0_RD: begin
        o_s_arvalid  = i_m0_arvalid & ~ar_done_q;
        o_s_araddr   = i_m0_araddr;
        o_s_arid     = i_m0_arid;
        o_s_arlen    = i_m0_arlen;
        o_s_arsize   = i_m0_arsize;
        o_s_arburst  = i_m0_arburst;
        o_m0_arready = i_s_arready;
        o_m0_rvalid  = i_s_rvalid;
        o_m0_rdata   = i_s_rdata;
        o_m0_rresp   = i_s_rresp;
        o_m0_rlast   = i_s_rlast;
        o_m0_rid     = i_s_rid;
        o_s_rready   = i_m0_rready;
      end
      S_M1_RD: begin
        o_s_arvalid  = i_m1_arvalid & ~ar_done_q;
        o_s_araddr   = i_m1_araddr;
        o_s_arid     = i_m1_arid;
        o_s_arlen    = i_m1_arlen;
        o_s_arsize   = i_m1_arsize;
        o_s_arburst  = i_m1_arburst;
        o_m1_arready = i_s_arready;
        o_m1_rvalid  = i_s_rvalid;
        o_m1_rdata   = i_s_rdata;
        o_m1_rresp   = i_s_rresp;
        o_m1_rlast   = i_s_rlast;
        o_m1_rid     = i_s_rid;
        o_s_rready   = i_m1_rready;
      end
      S_M1_WR: begin
        o_s_awvalid  = i_m1_awvalid & ~aw_done_q;
        o_s_awaddr   = i_m1_awaddr;
        o_s_awid     = i_m1_awid;
        o_s_awlen    = i_m1_awlen;
        o_s_awsize   = i_m1_awsize;
        o_s_awburst  = i_m1_awburst;
        o_m1_awready = i_s_awready;
        o_s_wvalid   = i_m1_wvalid & ~w_done_q;
        o_s_wdata    = i_m1_wdata;
        o_s_wstrb    = i_m1_wstrb;
        o_s_wlast    = i_m1_wlast;
        o_m1_wready  = i_s_wready;
        o_m1_bvalid  = i_s_bvalid;
        o_m1_bresp   = i_s_bresp;
        o_m1_bid     = i_s_bid;
        o_s_bready   = i_m1_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_24110006_axi_arbiter.sv
// Directed bench for the two-master AXI arbiter; the slave side is driven directly by the tasks.
module tb_ysyx_24110006_axi_arbiter;
  logic i_clock, i_reset;
  logic i_m0_arvalid; logic [31:0] i_m0_araddr; logic [3:0] i_m0_arid; logic [7:0] i_m0_arlen;
  logic [2:0] i_m0_arsize; logic [1:0] i_m0_arburst; logic o_m0_arready;
  logic o_m0_rvalid; logic [31:0] o_m0_rdata; logic [1:0] o_m0_rresp; logic o_m0_rlast; logic [3:0] o_m0_rid;
  logic i_m0_rready;
  logic i_m1_arvalid; logic [31:0] i_m1_araddr; logic [3:0] i_m1_arid; logic [7:0] i_m1_arlen;
  logic [2:0] i_m1_arsize; logic [1:0] i_m1_arburst; logic o_m1_arready;
  logic o_m1_rvalid; logic [31:0] o_m1_rdata; logic [1:0] o_m1_rresp; logic o_m1_rlast; logic [3:0] o_m1_rid;
  logic i_m1_rready;
  logic i_m1_awvalid; logic [31:0] i_m1_awaddr; logic [3:0] i_m1_awid; logic [7:0] i_m1_awlen;
  logic [2:0] i_m1_awsize; logic [1:0] i_m1_awburst; logic o_m1_awready;
  logic i_m1_wvalid; logic [31:0] i_m1_wdata; logic [3:0] i_m1_wstrb; logic i_m1_wlast; logic o_m1_wready;
  logic o_m1_bvalid; logic [1:0] o_m1_bresp; logic [3:0] o_m1_bid; logic i_m1_bready;
  logic o_s_awvalid; logic [31:0] o_s_awaddr; logic [3:0] o_s_awid; logic [7:0] o_s_awlen;
  logic [2:0] o_s_awsize; logic [1:0] o_s_awburst; logic i_s_awready;
  logic o_s_wvalid; logic [31:0] o_s_wdata; logic [3:0] o_s_wstrb; logic o_s_wlast; logic i_s_wready;
  logic i_s_bvalid; logic [1:0] i_s_bresp; logic [3:0] i_s_bid; logic o_s_bready;
  logic o_s_arvalid; logic [31:0] o_s_araddr; logic [3:0] o_s_arid; logic [7:0] o_s_arlen;
  logic [2:0] o_s_arsize; logic [1:0] o_s_arburst; logic i_s_arready;
  logic i_s_rvalid; logic [31:0] i_s_rdata; logic [1:0] i_s_rresp; logic i_s_rlast; logic [3:0] i_s_rid;
  logic o_s_rready;
  logic [1:0] o_dbg_state;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_M0_RD = 2'd1, ST_M1_RD = 2'd2, ST_M1_WR = 2'd3;

  ysyx_24110006_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_m0_arvalid(i_m0_arvalid), .i_m0_araddr(i_m0_araddr), .i_m0_arid(i_m0_arid), .i_m0_arlen(i_m0_arlen),
    .i_m0_arsize(i_m0_arsize), .i_m0_arburst(i_m0_arburst), .o_m0_arready(o_m0_arready),
    .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata), .o_m0_rresp(o_m0_rresp), .o_m0_rlast(o_m0_rlast),
    .o_m0_rid(o_m0_rid), .i_m0_rready(i_m0_rready),
    .i_m1_arvalid(i_m1_arvalid), .i_m1_araddr(i_m1_araddr), .i_m1_arid(i_m1_arid), .i_m1_arlen(i_m1_arlen),
    .i_m1_arsize(i_m1_arsize), .i_m1_arburst(i_m1_arburst), .o_m1_arready(o_m1_arready),
    .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata), .o_m1_rresp(o_m1_rresp), .o_m1_rlast(o_m1_rlast),
    .o_m1_rid(o_m1_rid), .i_m1_rready(i_m1_rready),
    .i_m1_awvalid(i_m1_awvalid), .i_m1_awaddr(i_m1_awaddr), .i_m1_awid(i_m1_awid), .i_m1_awlen(i_m1_awlen),
    .i_m1_awsize(i_m1_awsize), .i_m1_awburst(i_m1_awburst), .o_m1_awready(o_m1_awready),
    .i_m1_wvalid(i_m1_wvalid), .i_m1_wdata(i_m1_wdata), .i_m1_wstrb(i_m1_wstrb), .i_m1_wlast(i_m1_wlast),
    .o_m1_wready(o_m1_wready), .o_m1_bvalid(o_m1_bvalid), .o_m1_bresp(o_m1_bresp), .o_m1_bid(o_m1_bid),
    .i_m1_bready(i_m1_bready),
    .o_s_awvalid(o_s_awvalid), .o_s_awaddr(o_s_awaddr), .o_s_awid(o_s_awid), .o_s_awlen(o_s_awlen),
    .o_s_awsize(o_s_awsize), .o_s_awburst(o_s_awburst), .i_s_awready(i_s_awready),
    .o_s_wvalid(o_s_wvalid), .o_s_wdata(o_s_wdata), .o_s_wstrb(o_s_wstrb), .o_s_wlast(o_s_wlast),
    .i_s_wready(i_s_wready), .i_s_bvalid(i_s_bvalid), .i_s_bresp(i_s_bresp), .i_s_bid(i_s_bid),
    .o_s_bready(o_s_bready),
    .o_s_arvalid(o_s_arvalid), .o_s_araddr(o_s_araddr), .o_s_arid(o_s_arid), .o_s_arlen(o_s_arlen),
    .o_s_arsize(o_s_arsize), .o_s_arburst(o_s_arburst), .i_s_arready(i_s_arready),
    .i_s_rvalid(i_s_rvalid), .i_s_rdata(i_s_rdata), .i_s_rresp(i_s_rresp), .i_s_rlast(i_s_rlast),
    .i_s_rid(i_s_rid), .o_s_rready(o_s_rready),
    .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Driver tasks: inputs change right after the falling edge, checks follow #1 later.
  task automatic clear_inputs();
    i_m0_arvalid = 0; i_m0_araddr = '0; i_m0_arid = '0; i_m0_arlen = '0; i_m0_arsize = '0; i_m0_arburst = '0;
    i_m0_rready = 0;
    i_m1_arvalid = 0; i_m1_araddr = '0; i_m1_arid = '0; i_m1_arlen = '0; i_m1_arsize = '0; i_m1_arburst = '0;
    i_m1_rready = 0;
    i_m1_awvalid = 0; i_m1_awaddr = '0; i_m1_awid = '0; i_m1_awlen = '0; i_m1_awsize = '0; i_m1_awburst = '0;
    i_m1_wvalid = 0; i_m1_wdata = '0; i_m1_wstrb = '0; i_m1_wlast = 0; i_m1_bready = 0;
    i_s_awready = 0; i_s_wready = 0; i_s_bvalid = 0; i_s_bresp = '0; i_s_bid = '0;
    i_s_arready = 0; i_s_rvalid = 0; i_s_rdata = '0; i_s_rresp = '0; i_s_rlast = 0; i_s_rid = '0;
  endtask

  task automatic do_reset();
    @(negedge i_clock);
    clear_inputs();
    i_reset = 1;
    @(negedge i_clock);
    @(negedge i_clock);
    i_reset = 0;
  endtask

  task automatic test_reset();
    i_reset = 1;
    clear_inputs();
    repeat (3) @(negedge i_clock);
    i_reset = 0;
    // Slave noise while idle must not leak to either master.
    i_s_rvalid = 1; i_s_rdata = 32'hA5A5_A5A5; i_s_rlast = 1; i_s_arready = 1;
    i_s_bvalid = 1; i_s_bid = 4'h7; i_s_awready = 1; i_s_wready = 1;
    #1;
    checks++; if (o_dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state got %0d exp 0", o_dbg_state); end
    checks++; if (o_m0_rvalid !== 1'b0 || o_m0_rdata !== 32'h0) begin errors++; $display("FAIL rst_m0_r got %b/%h exp 0/0", o_m0_rvalid, o_m0_rdata); end
    checks++; if (o_m1_rvalid !== 1'b0 || o_m1_bvalid !== 1'b0 || o_m1_bid !== 4'h0) begin errors++; $display("FAIL rst_m1_rb got %b%b/%h exp 00/0", o_m1_rvalid, o_m1_bvalid, o_m1_bid); end
    checks++; if (o_m0_arready !== 1'b0 || o_m1_arready !== 1'b0 || o_m1_awready !== 1'b0 || o_m1_wready !== 1'b0) begin errors++; $display("FAIL rst_readies got %b%b%b%b exp 0000", o_m0_arready, o_m1_arready, o_m1_awready, o_m1_wready); end
    checks++; if (o_s_arvalid !== 1'b0 || o_s_awvalid !== 1'b0 || o_s_wvalid !== 1'b0 || o_s_rready !== 1'b0 || o_s_bready !== 1'b0) begin errors++; $display("FAIL rst_slave_hs got %b%b%b%b%b exp 00000", o_s_arvalid, o_s_awvalid, o_s_wvalid, o_s_rready, o_s_bready); end
    @(negedge i_clock);
    clear_inputs();
  endtask

  task automatic test_m0_read();
    @(negedge i_clock);
    i_m0_arvalid = 1; i_m0_araddr = 32'h8000_0000; i_m0_arid = 4'h3; i_m0_arsize = 3'd2; i_m0_arburst = 2'd1;
    i_m0_rready = 1; i_s_arready = 1;
    #1;
    checks++; if (o_s_arvalid !== 1'b0) begin errors++; $display("FAIL m0rd_idle_arvalid got %b exp 0", o_s_arvalid); end
    @(negedge i_clock); #1;
    checks++; if (o_dbg_state !== ST_M0_RD) begin errors++; $display("FAIL m0rd_state got %0d exp 1", o_dbg_state); end
    checks++; if (o_s_arvalid !== 1'b1 || o_s_araddr !== 32'h8000_0000 || o_s_arid !== 4'h3) begin errors++; $display("FAIL m0rd_ar got %b/%h/%h exp 1/80000000/3", o_s_arvalid, o_s_araddr, o_s_arid); end
    checks++; if (o_s_arsize !== 3'd2 || o_s_arburst !== 2'd1 || o_m0_arready !== 1'b1) begin errors++; $display("FAIL m0rd_ar_fields got %h/%h/%b exp 2/1/1", o_s_arsize, o_s_arburst, o_m0_arready); end
    @(negedge i_clock);
    i_m0_arvalid = 0; i_s_arready = 0;
    i_s_rvalid = 1; i_s_rdata = 32'h1234_5678; i_s_rlast = 1; i_s_rid = 4'h3; i_s_rresp = 2'b00;
    #1;
    checks++; if (o_m0_rvalid !== 1'b1 || o_m0_rdata !== 32'h1234_5678 || o_m0_rlast !== 1'b1 || o_m0_rid !== 4'h3) begin errors++; $display("FAIL m0rd_r got %b/%h/%b/%h exp 1/12345678/1/3", o_m0_rvalid, o_m0_rdata, o_m0_rlast, o_m0_rid); end
    checks++; if (o_s_rready !== 1'b1 || o_m1_rvalid !== 1'b0) begin errors++; $display("FAIL m0rd_route got %b/%b exp 1/0", o_s_rready, o_m1_rvalid); end
    @(negedge i_clock);
    clear_inputs();
    #1;
    checks++; if (o_dbg_state !== ST_IDLE) begin errors++; $display("FAIL m0rd_exit got %0d exp 0", o_dbg_state); end
  endtask

  // Both masters keep arvalid high throughout: grants must alternate and each address goes out once.
  task automatic test_round_robin();
    logic [1:0]  exp_st;
    logic [31:0] exp_addr;
    do_reset();
    i_m0_arvalid = 1; i_m0_araddr = 32'h8000_0000; i_m0_rready = 1;
    i_m1_arvalid = 1; i_m1_araddr = 32'h8000_0040; i_m1_rready = 1;
    for (int i = 0; i < 4; i++) begin
      exp_st   = (i % 2 == 0) ? ST_M0_RD : ST_M1_RD;
      exp_addr = (i % 2 == 0) ? 32'h8000_0000 : 32'h8000_0040;
      @(negedge i_clock); #1;
      checks++; if (o_dbg_state !== exp_st) begin errors++; $display("FAIL rr_grant_%0d got %0d exp %0d", i, o_dbg_state, exp_st); end
      checks++; if (o_s_arvalid !== 1'b1 || o_s_araddr !== exp_addr) begin errors++; $display("FAIL rr_ar_%0d got %b/%h exp 1/%h", i, o_s_arvalid, o_s_araddr, exp_addr); end
      i_s_arready = 1;
      @(negedge i_clock);
      i_s_arready = 0; i_s_rvalid = 1; i_s_rdata = 32'h100 + i; i_s_rlast = 1;
      #1;
      checks++; if (o_s_arvalid !== 1'b0) begin errors++; $display("FAIL rr_reissue_%0d got %b exp 0", i, o_s_arvalid); end
      if (exp_st == ST_M0_RD) begin
        checks++; if (o_m0_rvalid !== 1'b1 || o_m0_rdata !== 32'h100 + i || o_m1_rvalid !== 1'b0 || o_m1_arready !== 1'b0) begin errors++; $display("FAIL rr_r_%0d got %b/%h/%b/%b exp 1/%h/0/0", i, o_m0_rvalid, o_m0_rdata, o_m1_rvalid, o_m1_arready, 32'h100 + i); end
      end else begin
        checks++; if (o_m1_rvalid !== 1'b1 || o_m1_rdata !== 32'h100 + i || o_m0_rvalid !== 1'b0 || o_m0_arready !== 1'b0) begin errors++; $display("FAIL rr_r_%0d got %b/%h/%b/%b exp 1/%h/0/0", i, o_m1_rvalid, o_m1_rdata, o_m0_rvalid, o_m0_arready, 32'h100 + i); end
      end
      @(negedge i_clock);
      i_s_rvalid = 0; i_s_rlast = 0;
      if (i == 3) begin i_m0_arvalid = 0; i_m1_arvalid = 0; end
      #1;
      checks++; if (o_dbg_state !== ST_IDLE) begin errors++; $display("FAIL rr_exit_%0d got %0d exp 0", i, o_dbg_state); end
    end
    clear_inputs();
  endtask

  task automatic test_write_during_read();
    @(negedge i_clock);
    i_m0_arvalid = 1; i_m0_araddr = 32'h8000_0080; i_m0_rready = 1;
    @(negedge i_clock);
    i_m1_awvalid = 1; i_m1_awaddr = 32'h8000_0010; i_m1_awid = 4'h5; i_m1_awsize = 3'd2; i_m1_awburst = 2'd1;
    i_m1_wvalid = 1; i_m1_wdata = 32'hDEAD_BEEF; i_m1_wstrb = 4'b0011; i_m1_wlast = 1; i_m1_bready = 1;
    i_s_arready = 1;
    #1;
    checks++; if (o_dbg_state !== ST_M0_RD || o_s_awvalid !== 1'b0 || o_s_wvalid !== 1'b0) begin errors++; $display("FAIL wr_block_aw got %0d/%b/%b exp 1/0/0", o_dbg_state, o_s_awvalid, o_s_wvalid); end
    @(negedge i_clock);
    i_m0_arvalid = 0; i_s_arready = 0; i_s_awready = 1; i_s_wready = 1;
    i_s_rvalid = 1; i_s_rdata = 32'h0BAD_F00D; i_s_rlast = 1;
    #1;
    checks++; if (o_s_awvalid !== 1'b0 || o_m1_awready !== 1'b0 || o_m1_wready !== 1'b0) begin errors++; $display("FAIL wr_block_rdy got %b/%b/%b exp 0/0/0", o_s_awvalid, o_m1_awready, o_m1_wready); end
    checks++; if (o_m0_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL wr_m0_rdata got %h exp 0badf00d", o_m0_rdata); end
    @(negedge i_clock);
    i_s_rvalid = 0; i_s_rlast = 0;
    #1;
    checks++; if (o_dbg_state !== ST_IDLE || o_s_awvalid !== 1'b0) begin errors++; $display("FAIL wr_idle got %0d/%b exp 0/0", o_dbg_state, o_s_awvalid); end
    @(negedge i_clock); #1;
    checks++; if (o_dbg_state !== ST_M1_WR || o_s_awvalid !== 1'b1 || o_s_wvalid !== 1'b1) begin errors++; $display("FAIL wr_grant got %0d/%b/%b exp 3/1/1", o_dbg_state, o_s_awvalid, o_s_wvalid); end
    checks++; if (o_s_awaddr !== 32'h8000_0010 || o_s_wdata !== 32'hDEAD_BEEF || o_s_wstrb !== 4'b0011 || o_s_wlast !== 1'b1) begin errors++; $display("FAIL wr_fields got %h/%h/%b/%b exp 80000010/deadbeef/0011/1", o_s_awaddr, o_s_wdata, o_s_wstrb, o_s_wlast); end
    checks++; if (o_m1_awready !== 1'b1 || o_m1_wready !== 1'b1 || o_s_awid !== 4'h5) begin errors++; $display("FAIL wr_ready got %b/%b/%h exp 1/1/5", o_m1_awready, o_m1_wready, o_s_awid); end
    @(negedge i_clock);
    i_m1_awvalid = 0; i_m1_wvalid = 0; i_s_awready = 0; i_s_wready = 0;
    i_s_bvalid = 1; i_s_bid = 4'h5; i_s_bresp = 2'b10;
    #1;
    checks++; if (o_m1_bvalid !== 1'b1 || o_m1_bid !== 4'h5 || o_m1_bresp !== 2'b10 || o_s_bready !== 1'b1) begin errors++; $display("FAIL wr_b got %b/%h/%b/%b exp 1/5/10/1", o_m1_bvalid, o_m1_bid, o_m1_bresp, o_s_bready); end
    checks++; if (o_m0_rvalid !== 1'b0 || o_m0_arready !== 1'b0 || o_s_awvalid !== 1'b0) begin errors++; $display("FAIL wr_m0_quiet got %b/%b/%b exp 0/0/0", o_m0_rvalid, o_m0_arready, o_s_awvalid); end
    @(negedge i_clock);
    i_s_bvalid = 0;
    #1;
    checks++; if (o_dbg_state !== ST_IDLE || o_m1_bvalid !== 1'b0) begin errors++; $display("FAIL wr_exit got %0d/%b exp 0/0", o_dbg_state, o_m1_bvalid); end
    clear_inputs();
  endtask

  task automatic test_rready_stall();
    @(negedge i_clock);
    i_m0_arvalid = 1; i_m0_araddr = 32'h8000_00C0;
    @(negedge i_clock);
    i_s_arready = 1;
    @(negedge i_clock);
    i_m0_arvalid = 0; i_s_arready = 0;
    i_s_rvalid = 1; i_s_rdata = 32'hCAFE_F00D; i_s_rlast = 1; i_m0_rready = 0;
    i_m1_arvalid = 1; i_m1_araddr = 32'h8000_0100; i_m1_rready = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (o_m0_rvalid !== 1'b1 || o_m0_rdata !== 32'hCAFE_F00D || o_s_rready !== 1'b0) begin errors++; $display("FAIL stall_r_%0d got %b/%h/%b exp 1/cafef00d/0", i, o_m0_rvalid, o_m0_rdata, o_s_rready); end
      checks++; if (o_dbg_state !== ST_M0_RD || o_m1_arready !== 1'b0 || o_m1_rvalid !== 1'b0 || o_s_arvalid !== 1'b0) begin errors++; $display("FAIL stall_m1_quiet_%0d got %0d/%b/%b/%b exp 1/0/0/0", i, o_dbg_state, o_m1_arready, o_m1_rvalid, o_s_arvalid); end
      @(negedge i_clock);
    end
    i_m0_rready = 1;
    #1;
    checks++; if (o_s_rready !== 1'b1) begin errors++; $display("FAIL stall_release got %b exp 1", o_s_rready); end
    @(negedge i_clock);
    i_s_rvalid = 0; i_s_rlast = 0; i_m0_rready = 0;
    #1;
    checks++; if (o_dbg_state !== ST_IDLE) begin errors++; $display("FAIL stall_exit got %0d exp 0", o_dbg_state); end
    @(negedge i_clock);
    i_s_arready = 1;
    #1;
    checks++; if (o_dbg_state !== ST_M1_RD || o_s_arvalid !== 1'b1 || o_s_araddr !== 32'h8000_0100) begin errors++; $display("FAIL stall_m1_grant got %0d/%b/%h exp 2/1/80000100", o_dbg_state, o_s_arvalid, o_s_araddr); end
    @(negedge i_clock);
    i_m1_arvalid = 0; i_s_arready = 0; i_s_rvalid = 1; i_s_rdata = 32'h0000_0042; i_s_rlast = 1;
    #1;
    checks++; if (o_m1_rvalid !== 1'b1 || o_m1_rdata !== 32'h0000_0042 || o_m0_rvalid !== 1'b0) begin errors++; $display("FAIL stall_m1_r got %b/%h/%b exp 1/00000042/0", o_m1_rvalid, o_m1_rdata, o_m0_rvalid); end
    @(negedge i_clock);
    clear_inputs();
  endtask

  task automatic test_reset_mid_write();
    @(negedge i_clock);
    i_m1_awvalid = 1; i_m1_awaddr = 32'h8000_0200; i_m1_awid = 4'h9;
    i_m1_wvalid = 1; i_m1_wdata = 32'h5555_AAAA; i_m1_wstrb = 4'hF; i_m1_wlast = 1; i_m1_bready = 1;
    @(negedge i_clock);
    i_s_awready = 1;
    #1;
    checks++; if (o_dbg_state !== ST_M1_WR) begin errors++; $display("FAIL rstwr_state got %0d exp 3", o_dbg_state); end
    @(negedge i_clock);
    i_m1_awvalid = 0; i_s_awready = 0;
    #1;
    checks++; if (o_s_awvalid !== 1'b0 || o_s_wvalid !== 1'b1) begin errors++; $display("FAIL rstwr_awdone got %b/%b exp 0/1", o_s_awvalid, o_s_wvalid); end
    i_reset = 1;
    @(negedge i_clock);
    i_reset = 0; i_m1_wvalid = 0;
    i_s_bvalid = 1; i_s_bid = 4'h9;
    #1;
    checks++; if (o_dbg_state !== ST_IDLE || o_m1_bvalid !== 1'b0 || o_m1_bid !== 4'h0 || o_s_bready !== 1'b0 || o_s_wvalid !== 1'b0) begin errors++; $display("FAIL rstwr_idle got %0d/%b/%h/%b/%b exp 0/0/0/0/0", o_dbg_state, o_m1_bvalid, o_m1_bid, o_s_bready, o_s_wvalid); end
    clear_inputs();
    i_m0_arvalid = 1; i_m0_araddr = 32'h8000_0300; i_m0_rready = 1;
    @(negedge i_clock);
    i_s_arready = 1;
    #1;
    checks++; if (o_dbg_state !== ST_M0_RD || o_s_arvalid !== 1'b1 || o_s_araddr !== 32'h8000_0300) begin errors++; $display("FAIL rstwr_m0_ar got %0d/%b/%h exp 1/1/80000300", o_dbg_state, o_s_arvalid, o_s_araddr); end
    @(negedge i_clock);
    i_m0_arvalid = 0; i_s_arready = 0; i_s_rvalid = 1; i_s_rdata = 32'h7777_1111; i_s_rlast = 1;
    #1;
    checks++; if (o_m0_rvalid !== 1'b1 || o_m0_rdata !== 32'h7777_1111 || o_m0_rlast !== 1'b1) begin errors++; $display("FAIL rstwr_m0_r got %b/%h/%b exp 1/77771111/1", o_m0_rvalid, o_m0_rdata, o_m0_rlast); end
    @(negedge i_clock);
    clear_inputs();
    #1;
    checks++; if (o_dbg_state !== ST_IDLE) begin errors++; $display("FAIL rstwr_m0_exit got %0d exp 0", o_dbg_state); end
  endtask

  initial begin
    test_reset();
    test_m0_read();
    test_round_robin();
    test_write_during_read();
    test_rready_stall();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
